// File: rtl/tt_trng_pkg.sv
// tt_trng_pkg: shared definitions for the entropy collector.
//   - trng_state_t : collector FSM states (WARMUP, COLLECT, FAILED)
//   - WORD_W, FIFO_DEPTH, REP_LIMIT, WARMUP_BITS : default parameter values
package tt_trng_pkg;

    localparam int WORD_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int REP_LIMIT   = 8;
    localparam int WARMUP_BITS = 16;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAILED  = 2'd2
    } trng_state_t;

endpackage

// File: rtl/tt_sync_fifo.sv
// tt_sync_fifo: single-clock FIFO with synchronous active-high reset.
//   clk, rst_n : clock, synchronous reset (active-high)
//   push, din  : write request and data; ignored when full unless a pop
//                happens on the same edge
//   pop        : read request; ignored when empty
//   dout       : head entry, forced to 0 while empty
//   full, empty, count : occupancy status
// Handshake: a push writes on the edge where push is high and the FIFO
// has room after any same-edge pop; a pop retires the head on the edge
// where pop is high and the FIFO is not empty.
// DEPTH must be a power of 2 (at least 2) so the pointers wrap naturally.
module tt_sync_fifo
    import tt_trng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a push while full succeeds.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tt_entropy_collector.sv
// tt_entropy_collector: assembles serial entropy bits into words, runs a
// repetition-count health test and buffers words in a small FIFO.
//   clk         : rising-edge clock
//   rst_n       : synchronous reset, active-high (despite the name)
//   bit_in      : serial random bit
//   bit_valid   : bit_in accepted on this edge when high
//   clear_fail  : pulse; clears overflow, and leaves FAILED for WARMUP
//   word_ready  : consumer accepts word_out
//   word_out    : FIFO head word (0 when empty)
//   word_valid  : FIFO not empty
//   fifo_count  : words held
//   health_fail : sticky repetition-test failure
//   overflow    : sticky, a completed word was dropped on a full FIFO
//   state       : current FSM state, for observation
// Handshake: a word transfers on every edge where word_valid and
// word_ready are both high; bits transfer on every edge with bit_valid.
module tt_entropy_collector
    import tt_trng_pkg::*;
#(
    parameter int WORD_W      = tt_trng_pkg::WORD_W,
    parameter int FIFO_DEPTH  = tt_trng_pkg::FIFO_DEPTH,
    parameter int REP_LIMIT   = tt_trng_pkg::REP_LIMIT,
    parameter int WARMUP_BITS = tt_trng_pkg::WARMUP_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          clear_fail,
    input  logic                          word_ready,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          health_fail,
    output logic                          overflow,
    output trng_state_t                   state
);

    localparam int BW  = $clog2(WORD_W);
    localparam int WMW = $clog2(WARMUP_BITS + 1);
    localparam int RW  = $clog2(REP_LIMIT + 1);

    trng_state_t       state_next;
    logic [BW-1:0]     bit_cnt;
    logic [WMW-1:0]    warm_cnt;
    logic [RW-1:0]     run_cnt;
    logic [RW-1:0]     run_inc;
    logic              last_bit;
    logic [WORD_W-1:0] asm_reg;
    logic [WORD_W-1:0] word_next;
    logic              accept;
    logic              fail_hit;
    logic              warm_done;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign word_valid = !fifo_empty;
    assign pop        = word_valid && word_ready;

    // Next-state and per-bit decisions.
    always_comb begin
        state_next = state;
        run_inc    = RW'(1);
        word_next  = {bit_in, asm_reg[WORD_W-1:1]};
        accept     = bit_valid && (state != ST_FAILED);
        fail_hit   = 1'b0;
        warm_done  = 1'b0;
        push       = 1'b0;

        // run_cnt == 0 means no bit seen since reset/clear: start a new run.
        if (run_cnt != '0 && bit_in == last_bit) begin
            run_inc = (run_cnt == RW'(REP_LIMIT)) ? run_cnt : run_cnt + RW'(1);
        end
        fail_hit = accept && (run_inc == RW'(REP_LIMIT));

        case (state)
            ST_WARMUP: begin
                warm_done = accept && (warm_cnt == WMW'(WARMUP_BITS - 1));
                if (fail_hit) begin
                    state_next = ST_FAILED;
                end else if (warm_done) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A word whose last bit trips the health test is discarded.
                push = accept && !fail_hit && (bit_cnt == BW'(WORD_W - 1));
                if (fail_hit) begin
                    state_next = ST_FAILED;
                end
            end
            ST_FAILED: begin
                if (clear_fail) begin
                    state_next = ST_WARMUP;
                end
            end
            default: state_next = ST_WARMUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_WARMUP;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bit_cnt     <= '0;
            warm_cnt    <= '0;
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            asm_reg     <= '0;
            health_fail <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            // Clear has priority over a drop on the same edge.
            if (clear_fail) begin
                overflow <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end

            if (state == ST_FAILED) begin
                if (clear_fail) begin
                    health_fail <= 1'b0;
                    run_cnt     <= '0;
                    warm_cnt    <= '0;
                end
            end else if (accept) begin
                last_bit <= bit_in;
                run_cnt  <= run_inc;
                if (fail_hit) begin
                    health_fail <= 1'b1;
                    asm_reg     <= '0;
                    bit_cnt     <= '0;
                    warm_cnt    <= '0;
                end else if (state == ST_WARMUP) begin
                    warm_cnt <= warm_done ? '0 : warm_cnt + WMW'(1);
                end else begin
                    asm_reg <= word_next;
                    bit_cnt <= (bit_cnt == BW'(WORD_W - 1)) ? '0 : bit_cnt + BW'(1);
                end
            end
        end
    end

    tt_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (word_next),
        .pop   (pop),
        .dout  (word_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_tt_entropy_collector.sv
module tb_tt_entropy_collector;
    import tt_trng_pkg::*;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int REP = 8;
    localparam int WU  = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              bit_in;
    logic              bit_valid;
    logic              clear_fail;
    logic              word_ready;
    logic [W-1:0]      word_out;
    logic              word_valid;
    logic [$clog2(D):0] fifo_count;
    logic              health_fail;
    logic              overflow;
    trng_state_t       state;

    tt_entropy_collector #(
        .WORD_W      (W),
        .FIFO_DEPTH  (D),
        .REP_LIMIT   (REP),
        .WARMUP_BITS (WU)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clear_fail  (clear_fail),
        .word_ready  (word_ready),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .fifo_count  (fifo_count),
        .health_fail (health_fail),
        .overflow    (overflow),
        .state       (state)
    );

    int tests = 0;
    int fails = 0;

    // reference model: behaviour described per accepted bit
    trng_state_t  m_state;
    int           m_warm;
    int           m_run;
    bit           m_last;
    int           m_nb;
    logic [W-1:0] m_word;
    bit           m_hf;
    bit           m_ov;
    logic [W-1:0] exp_q[$];

    task automatic model_reset();
        m_state = ST_WARMUP;
        m_warm  = 0;
        m_run   = 0;
        m_last  = 1'b0;
        m_nb    = 0;
        m_word  = '0;
        m_hf    = 1'b0;
        m_ov    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input bit b, input bit rdy, input bit clr);
        bit           do_push;
        logic [W-1:0] done_word;
        do_push   = 1'b0;
        done_word = '0;
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_state == ST_FAILED) begin
            if (clr) begin
                m_state = ST_WARMUP;
                m_warm  = 0;
                m_run   = 0;
                m_hf    = 1'b0;
            end
        end else if (v) begin
            if (m_run == 0 || b != m_last) m_run = 1;
            else if (m_run < REP) m_run = m_run + 1;
            m_last = b;
            if (m_run == REP) begin
                m_state = ST_FAILED;
                m_hf    = 1'b1;
                m_nb    = 0;
                m_word  = '0;
            end else if (m_state == ST_WARMUP) begin
                m_warm = m_warm + 1;
                if (m_warm == WU) begin
                    m_state = ST_COLLECT;
                    m_warm  = 0;
                end
            end else begin
                m_word[m_nb] = b;
                m_nb = m_nb + 1;
                if (m_nb == W) begin
                    do_push   = 1'b1;
                    done_word = m_word;
                    m_word    = '0;
                    m_nb      = 0;
                end
            end
        end
        if (do_push) begin
            if (exp_q.size() == D) m_ov = 1'b1;
            else exp_q.push_back(done_word);
        end
        if (clr) m_ov = 1'b0;
    endtask

    // scoreboard comparisons
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("word_valid", 32'(word_valid), 32'(exp_q.size() > 0));
        check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check("word_out", 32'(word_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
        check("health_fail", 32'(health_fail), 32'(m_hf));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("state", 32'(state), 32'(m_state));
    endtask

    // driver tasks
    task automatic cycle(input bit v, input bit b, input bit rdy, input bit clr);
        bit_valid  = v;
        bit_in     = b;
        word_ready = rdy;
        clear_fail = clr;
        @(posedge clk);
        model_step(v, b, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n      = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        word_ready = 1'b0;
        clear_fail = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b0;
        check_all();
    endtask

    // alternating 1,0,...,0 so the final warmup bit is 0
    task automatic warmup();
        for (int i = 0; i < WU; i++) cycle(1'b1, (i % 2) == 0, 1'b0, 1'b0);
    endtask

    // random bit that never completes a repetition run
    function automatic bit safe_bit();
        bit r;
        r = 1'($urandom_range(0, 1));
        if (m_run == REP - 1) r = !m_last;
        return r;
    endfunction

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] first_word;
        logic [W-1:0] fresh_word;
        bit           b;

        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        clear_fail = 1'b0;
        word_ready = 1'b0;
        model_reset();
        @(posedge clk);

        // reset state
        do_reset();
        check("rst_word_out", 32'(word_out), 32'd0);
        check("rst_state", 32'(state), 32'(ST_WARMUP));

        // warmup then the 1,0,1,1,0,0,1,0 word
        warmup();
        check("warm_done_state", 32'(state), 32'(ST_COLLECT));
        pat = 8'b0100_1101;
        for (int i = 0; i < W; i++) cycle(1'b1, pat[i], 1'b0, 1'b0);
        check("word_4d", 32'(word_out), 32'h4D);
        check("word_4d_valid", 32'(word_valid), 32'd1);
        check("word_4d_count", 32'(fifo_count), 32'd1);

        // eight ones trip the health test, further bits are ignored
        for (int i = 0; i < REP; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rep_fail", 32'(health_fail), 32'd1);
        check("rep_state", 32'(state), 32'(ST_FAILED));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("failed_count", 32'(fifo_count), 32'd1);

        // clear_fail leaves FAILED and restarts warmup
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_hf", 32'(health_fail), 32'd0);
        check("clear_state", 32'(state), 32'(ST_WARMUP));
        warmup();
        check("rewarm_state", 32'(state), 32'(ST_COLLECT));

        // drain, then five words with no consumer
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        first_word = '0;
        for (int i = 0; i < 5 * W; i++) begin
            b = safe_bit();
            if (i < W) first_word[i] = b;
            cycle(1'b1, b, 1'b0, 1'b0);
        end
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(word_out), 32'(first_word));

        // clear_fail in COLLECT only clears overflow
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_clear", 32'(overflow), 32'd0);
        check("ovf_clear_state", 32'(state), 32'(ST_COLLECT));

        // push and pop together while full
        for (int i = 0; i < W - 1; i++) cycle(1'b1, safe_bit(), 1'b0, 1'b0);
        cycle(1'b1, safe_bit(), 1'b1, 1'b0);
        check("full_pp_count", 32'(fifo_count), 32'd4);
        check("full_pp_ovf", 32'(overflow), 32'd0);

        // reset mid-word discards everything
        for (int i = 0; i < 5; i++) cycle(1'b1, safe_bit(), 1'b0, 1'b0);
        do_reset();
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_valid", 32'(word_valid), 32'd0);
        check("midrst_word", 32'(word_out), 32'd0);
        warmup();
        fresh_word = '0;
        for (int i = 0; i < W; i++) begin
            b = safe_bit();
            fresh_word[i] = b;
            cycle(1'b1, b, 1'b0, 1'b0);
        end
        check("fresh_count", 32'(fifo_count), 32'd1);
        check("fresh_word", 32'(word_out), 32'(fresh_word));

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 200) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
